note_source_arbiter: RTL and testbench

- Parametrised, registered successor to the top-level note/octave mode multiplexer.
- Arbitrates N_SRC player input channels (keypad, PS/2 keyboard, future sources) plus the auto-play score channel onto the buzzer path and the scoring path.
- Adds priority, last-active and timed player-override modes, plus a muted gap on mode change.
- Sits between the piano_* input decoders / music_score_controller and pitch_generator / game_statistics / Seg7Device.

---
 rtl/cm_pkg.sv | 26 ++
 rtl/note_source_arbiter_lowest_set_index.sv | 26 ++
 rtl/note_source_arbiter.sv | 255 +++++++++++++++++++++++++
 tb/tb_note_source_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cm_pkg.sv
// Shared definitions for the note source arbiter slice.
// Holds the mode encodings, the rest/default-octave constants, the
// NORMAL/GAP state type and a small helper used to size timers.
package cm_pkg;

    typedef enum logic [2:0] {
        MODE_FIXED         = 3'd0,
        MODE_PRIORITY      = 3'd1,
        MODE_LAST_ACTIVE   = 3'd2,
        MODE_AUTO_OVERRIDE = 3'd3,
        MODE_MUTE          = 3'd4
    } mode_e;

    localparam logic [3:0] REST_NOTE      = 4'd0;
    localparam logic [3:0] DEFAULT_OCTAVE = 4'd4;

    typedef enum logic {
        NORMAL = 1'b0,
        GAP    = 1'b1
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/note_source_arbiter_lowest_set_index.sv
// Priority scan: reports the index of the lowest set bit of vec.
// Ports:
//   vec   - input vector of N request bits
//   index - position of the lowest set bit ('0 when none set)
//   found - 1 when at least one bit of vec is set
module lowest_set_index #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] index,
    output logic         found
);

    always_comb begin
        index = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (vec[i] && !found) begin
                index = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/note_source_arbiter.sv
// Note source arbiter: selects one of N_SRC player channels or the auto-play
// score channel and drives the buzzer path (note/octave), the scoring path
// (input_note/input_octave) and the 7-segment octave field. All outputs are
// registered. A mode change inserts a muted gap of GAP_TICKS tick strobes.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   tick              - 1 ms single-cycle strobe
//   mode, sel         - operating mode, FIXED-mode channel index
//   src_note/octave   - packed per-channel note/octave, channel i at [4i+3:4i]
//   src_press         - per-channel keypress pulses
//   auto_note/octave  - score channel
//   note, octave      - to pitch_generator
//   input_note/octave - to game_statistics
//   active_src/valid  - selected player channel and its validity
//   override          - timed player override active
//   octave_display    - {channel+1, octave} display field
module note_source_arbiter
    import cm_pkg::*;
#(
    parameter int N_SRC      = 4,
    parameter int SEL_W      = 2,
    parameter int HOLD_TICKS = 500,
    parameter int GAP_TICKS  = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic [2:0]           mode,
    input  logic [SEL_W-1:0]     sel,
    input  logic [4*N_SRC-1:0]   src_note,
    input  logic [4*N_SRC-1:0]   src_octave,
    input  logic [N_SRC-1:0]     src_press,
    input  logic [3:0]           auto_note,
    input  logic [3:0]           auto_octave,
    output logic [3:0]           note,
    output logic [3:0]           octave,
    output logic [3:0]           input_note,
    output logic [3:0]           input_octave,
    output logic [SEL_W-1:0]     active_src,
    output logic                 active_valid,
    output logic                 override,
    output logic [7:0]           octave_display
);

    localparam int TMR_MAX = max_int(max_int(HOLD_TICKS, GAP_TICKS), 1);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_TICKS);
    localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_TICKS);

    state_e             state_q, state_d;
    logic [2:0]         mode_q;
    logic [TMR_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [TMR_W-1:0]   ovr_cnt_q, ovr_cnt_d;
    logic [SEL_W-1:0]   ovr_idx_q, ovr_idx_d;
    logic [SEL_W-1:0]   last_idx_q, last_idx_d;
    logic               seen_q, seen_d;
    logic               ovr_d;

    logic [N_SRC-1:0]   active_mask;
    logic [SEL_W-1:0]   prio_idx, press_idx;
    logic               prio_found, press_found;

    logic [SEL_W-1:0]   pick;
    logic               use_chan, use_auto, blank;
    logic               valid_d;
    logic [SEL_W-1:0]   src_d;
    logic [3:0]         ch_note, ch_octave;
    logic [3:0]         note_d, octave_d, in_note_d, in_octave_d;
    logic [SEL_W-1:0]   src_inc;
    logic [SEL_W+3:0]   src_inc_ext;
    logic [7:0]         display_d;

    always_comb begin
        active_mask = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            active_mask[i] = (src_note[4*i +: 4] != REST_NOTE);
        end
    end

    lowest_set_index #(.N(N_SRC), .W(SEL_W)) u_prio_scan (
        .vec   (active_mask),
        .index (prio_idx),
        .found (prio_found)
    );

    lowest_set_index #(.N(N_SRC), .W(SEL_W)) u_press_scan (
        .vec   (src_press),
        .index (press_idx),
        .found (press_found)
    );

    // Next-state, timers and channel selection. Output registers are loaded
    // from the post-update state so every input reaches the outputs in 1 clk.
    always_comb begin
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        ovr_cnt_d  = ovr_cnt_q;
        ovr_idx_d  = ovr_idx_q;
        ovr_d      = override;
        last_idx_d = last_idx_q;
        seen_d     = seen_q;
        pick       = '0;
        use_chan   = 1'b0;
        use_auto   = 1'b0;
        blank      = 1'b0;
        valid_d    = 1'b0;
        src_d      = active_src;

        if (press_found) begin
            last_idx_d = press_idx;
            seen_d     = 1'b1;
        end

        if ((GAP_TICKS > 0) && (mode != mode_q)) begin
            state_d   = GAP;
            gap_cnt_d = GAP_LOAD;
        end else if ((state_q == GAP) && tick) begin
            gap_cnt_d = (gap_cnt_q == '0) ? '0 : gap_cnt_q - 1'b1;
            if (gap_cnt_d == '0) begin
                state_d = NORMAL;
            end
        end

        // A press on the expiry tick takes the reload branch, so override holds.
        if ((state_d == GAP) || (mode != MODE_AUTO_OVERRIDE)) begin
            ovr_d     = 1'b0;
            ovr_cnt_d = '0;
        end else if (press_found) begin
            ovr_d     = 1'b1;
            ovr_idx_d = press_idx;
            ovr_cnt_d = HOLD_LOAD;
        end else if (override && tick) begin
            ovr_cnt_d = (ovr_cnt_q == '0) ? '0 : ovr_cnt_q - 1'b1;
            if (ovr_cnt_d == '0) begin
                ovr_d = 1'b0;
            end
        end

        if (state_d == GAP) begin
            blank = 1'b1;
        end else begin
            case (mode)
                MODE_FIXED: begin
                    if ({1'b0, sel} < (SEL_W+1)'(N_SRC)) begin
                        pick     = sel;
                        use_chan = 1'b1;
                        valid_d  = 1'b1;
                        src_d    = sel;
                    end
                end
                MODE_PRIORITY: begin
                    if (prio_found) begin
                        pick     = prio_idx;
                        use_chan = 1'b1;
                        valid_d  = 1'b1;
                        src_d    = prio_idx;
                    end
                end
                MODE_LAST_ACTIVE: begin
                    pick     = last_idx_d;
                    use_chan = 1'b1;
                    valid_d  = seen_d;
                    src_d    = last_idx_d;
                end
                MODE_AUTO_OVERRIDE: begin
                    if (ovr_d) begin
                        pick     = ovr_idx_d;
                        use_chan = 1'b1;
                        valid_d  = 1'b1;
                        src_d    = ovr_idx_d;
                    end else begin
                        use_auto = 1'b1;
                    end
                end
                default: blank = 1'b1;
            endcase
        end
    end

    always_comb begin
        ch_note   = REST_NOTE;
        ch_octave = DEFAULT_OCTAVE;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (pick == SEL_W'(i)) begin
                ch_note   = src_note[4*i +: 4];
                ch_octave = src_octave[4*i +: 4];
            end
        end
    end

    always_comb begin
        note_d      = REST_NOTE;
        octave_d    = DEFAULT_OCTAVE;
        in_note_d   = REST_NOTE;
        in_octave_d = DEFAULT_OCTAVE;
        if (use_chan) begin
            note_d      = ch_note;
            octave_d    = ch_octave;
            in_note_d   = ch_note;
            in_octave_d = ch_octave;
        end else if (use_auto) begin
            note_d      = auto_note;
            octave_d    = auto_octave;
            in_octave_d = auto_octave;
        end

        // Channel number wraps in SEL_W bits, then is fitted to the 4-bit digit.
        src_inc     = src_d + 1'b1;
        src_inc_ext = {4'b0000, src_inc};
        if (blank) begin
            display_d = 8'h00;
        end else if (valid_d) begin
            display_d = {src_inc_ext[3:0], octave_d};
        end else begin
            display_d = {4'h0, octave_d};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= NORMAL;
            mode_q         <= MODE_FIXED;
            gap_cnt_q      <= '0;
            ovr_cnt_q      <= '0;
            ovr_idx_q      <= '0;
            last_idx_q     <= '0;
            seen_q         <= 1'b0;
            note           <= REST_NOTE;
            octave         <= DEFAULT_OCTAVE;
            input_note     <= REST_NOTE;
            input_octave   <= DEFAULT_OCTAVE;
            active_src     <= '0;
            active_valid   <= 1'b0;
            override       <= 1'b0;
            octave_display <= 8'h00;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode;
            gap_cnt_q      <= gap_cnt_d;
            ovr_cnt_q      <= ovr_cnt_d;
            ovr_idx_q      <= ovr_idx_d;
            last_idx_q     <= last_idx_d;
            seen_q         <= seen_d;
            note           <= note_d;
            octave         <= octave_d;
            input_note     <= in_note_d;
            input_octave   <= in_octave_d;
            active_src     <= src_d;
            active_valid   <= valid_d;
            override       <= ovr_d;
            octave_display <= display_d;
        end
    end

endmodule

// File: tb/tb_note_source_arbiter.sv
// Scoreboard bench for note_source_arbiter: stimulus issues one cycle of
// inputs, a behavioural model pushes the expected registered outputs, and a
// monitor pops and compares them one clock later.
module tb_note_source_arbiter;

    localparam int N    = 4;
    localparam int SW   = 3;
    localparam int HOLD = 3;
    localparam int GAPT = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           tick;
    logic [2:0]     mode;
    logic [SW-1:0]  sel;
    logic [4*N-1:0] src_note;
    logic [4*N-1:0] src_octave;
    logic [N-1:0]   src_press;
    logic [3:0]     auto_note;
    logic [3:0]     auto_octave;
    logic [3:0]     note, octave, input_note, input_octave;
    logic [SW-1:0]  active_src;
    logic           active_valid;
    logic           override;
    logic [7:0]     octave_display;

    note_source_arbiter #(
        .N_SRC(N), .SEL_W(SW), .HOLD_TICKS(HOLD), .GAP_TICKS(GAPT)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .mode(mode), .sel(sel),
        .src_note(src_note), .src_octave(src_octave), .src_press(src_press),
        .auto_note(auto_note), .auto_octave(auto_octave),
        .note(note), .octave(octave), .input_note(input_note),
        .input_octave(input_octave), .active_src(active_src),
        .active_valid(active_valid), .override(override),
        .octave_display(octave_display)
    );

    always #5 clk = ~clk;

    typedef struct {
        int note; int oct; int in_note; int in_oct;
        int src; int valid; int ovr; int disp;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Model state: elapsed ticks since the last mode change / last override
    // press, rather than down-counters.
    int m_prev_mode, m_since_change, m_armed, m_since_press, m_ovr_ch;
    int m_last, m_seen, m_src;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_prev_mode    = 0;
        m_since_change = GAPT;
        m_armed        = 0;
        m_since_press  = 0;
        m_ovr_ch       = 0;
        m_last         = 0;
        m_seen         = 0;
        m_src          = 0;
    endfunction

    task automatic model_step();
        int nt[N];
        int oc[N];
        int pidx, chan, md, ovr;
        bit muted, blank, use_auto;
        exp_t e;
        md = int'(mode);
        pidx = -1;
        for (int i = 0; i < N; i++) begin
            nt[i] = int'(src_note[4*i +: 4]);
            oc[i] = int'(src_octave[4*i +: 4]);
            if (src_press[i] && pidx < 0) pidx = i;
        end
        if (pidx >= 0) begin m_last = pidx; m_seen = 1; end

        if (md != m_prev_mode) m_since_change = 0;
        else if (tick && m_since_change < GAPT) m_since_change++;
        m_prev_mode = md;
        muted = (m_since_change < GAPT);

        if (muted || md != 3) m_armed = 0;
        else if (pidx >= 0) begin m_armed = 1; m_since_press = 0; m_ovr_ch = pidx; end
        else if (tick && m_armed != 0) m_since_press++;
        ovr = (m_armed != 0 && m_since_press < HOLD) ? 1 : 0;
        if (ovr == 0) m_armed = 0;

        e = '{note: 0, oct: 4, in_note: 0, in_oct: 4, src: m_src, valid: 0, ovr: ovr, disp: 0};
        chan = -1; blank = 0; use_auto = 0;
        if (muted) blank = 1;
        else begin
            case (md)
                0: if (int'(sel) < N) chan = int'(sel);
                1: for (int i = N - 1; i >= 0; i--) if (nt[i] != 0) chan = i;
                2: chan = m_last;
                3: if (ovr != 0) chan = m_ovr_ch; else use_auto = 1;
                default: blank = 1;
            endcase
        end
        if (chan >= 0) begin
            e.note = nt[chan]; e.oct = oc[chan];
            e.in_note = nt[chan]; e.in_oct = oc[chan];
            e.valid = (md == 2) ? m_seen : 1;
            m_src = chan;
            e.src = chan;
        end else if (use_auto) begin
            e.note = int'(auto_note); e.oct = int'(auto_octave); e.in_oct = int'(auto_octave);
        end
        if (blank) e.disp = 0;
        else if (e.valid != 0) e.disp = ((((e.src + 1) % (1 << SW)) & 15) * 16) + e.oct;
        else e.disp = e.oct;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("note",           32'(note),           32'(e.note));
            chk("octave",         32'(octave),         32'(e.oct));
            chk("input_note",     32'(input_note),     32'(e.in_note));
            chk("input_octave",   32'(input_octave),   32'(e.in_oct));
            chk("active_src",     32'(active_src),     32'(e.src));
            chk("active_valid",   32'(active_valid),   32'(e.valid));
            chk("override",       32'(override),       32'(e.ovr));
            chk("octave_display", 32'(octave_display), 32'(e.disp));
        end
    end

    task automatic cycle();
        model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_ch(input int i, input int n, input int o);
        src_note[4*i +: 4]   = 4'(n);
        src_octave[4*i +: 4] = 4'(o);
    endtask

    // Change mode and clock through the full muted gap.
    task automatic set_mode(input int m);
        mode = 3'(m);
        tick = 1'b0;
        cycle();
        tick = 1'b1;
        repeat (GAPT) cycle();
        tick = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_note"},     32'(note),           32'd0);
        chk({tag, "_octave"},   32'(octave),         32'd4);
        chk({tag, "_in_note"},  32'(input_note),     32'd0);
        chk({tag, "_in_oct"},   32'(input_octave),   32'd4);
        chk({tag, "_src"},      32'(active_src),     32'd0);
        chk({tag, "_valid"},    32'(active_valid),   32'd0);
        chk({tag, "_override"}, 32'(override),       32'd0);
        chk({tag, "_display"},  32'(octave_display), 32'h00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; tick = 1'b0; mode = 3'd0; sel = '0;
        src_note = '0; src_octave = '0; src_press = '0;
        auto_note = '0; auto_octave = '0;
        model_reset();
        #3;
        check_reset_values("reset");
        @(posedge clk); #2;
        rst = 1'b0;

        // PRIORITY: lowest active channel wins, falls to ch3 on release
        set_mode(1);
        set_ch(1, 3, 5); set_ch(3, 7, 2);
        cycle();
        set_ch(1, 0, 5);
        cycle();
        set_ch(3, 0, 2);
        cycle();

        // gap: 1 -> 2 with ch0 active, then a mode change inside the gap
        set_ch(0, 9, 3);
        mode = 3'd2; tick = 1'b1;
        cycle(); cycle();
        mode = 3'd1;
        cycle(); cycle(); cycle(); cycle();
        mode = 3'd2;
        cycle(); cycle(); cycle(); cycle();
        tick = 1'b0;

        // LAST_ACTIVE: simultaneous presses, then a press on a resting channel
        src_press = 4'b0101; cycle();
        src_press = 4'b0000; cycle();
        set_ch(3, 0, 6);
        src_press = 4'b1000; cycle();
        src_press = 4'b0000; cycle();

        // AUTO_OVERRIDE: hold for HOLD ticks, re-press extends, press on expiry
        set_mode(3);
        auto_note = 4'd1; auto_octave = 4'd4;
        set_ch(1, 6, 5);
        src_press = 4'b0010; cycle();
        src_press = 4'b0000;
        repeat (4) begin tick = 1'b1; cycle(); tick = 1'b0; cycle(); end
        src_press = 4'b0010; cycle();
        src_press = 4'b0000;
        tick = 1'b1; cycle(); cycle();
        src_press = 4'b0010; cycle();
        src_press = 4'b0000;
        cycle(); cycle(); cycle(); cycle();
        tick = 1'b0;
        src_press = 4'b0010; cycle();
        src_press = 4'b0000;
        tick = 1'b1; cycle(); cycle();
        src_press = 4'b0010; cycle();
        src_press = 4'b0000; tick = 1'b0; cycle();

        // reset in the middle of an override
        set_ch(1, 5, 5);
        src_press = 4'b0010; cycle();
        src_press = 4'b0000;
        chk("pre_reset_override", 32'(override), 32'd1);
        chk("pre_reset_note", 32'(note), 32'd5);
        rst = 1'b1;
        #1;
        check_reset_values("async_reset");
        @(posedge clk); #2;
        rst = 1'b0;
        model_reset();

        // FIXED with out-of-range select, then an undefined mode
        set_mode(0);
        set_ch(2, 11, 7);
        sel = 3'd5; cycle();
        sel = 3'd4; cycle();
        sel = 3'd2; cycle();
        mode = 3'd6; cycle(); cycle();

        // randomized traffic
        repeat (3000) begin
            if ($urandom_range(0, 19) == 0) mode = 3'($urandom_range(0, 7));
            sel = 3'($urandom_range(0, 7));
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) set_ch(i, $urandom_range(1, 15), $urandom_range(0, 15));
                else if ($urandom_range(0, 3) == 0) set_ch(i, 0, $urandom_range(0, 15));
                src_press[i] = ($urandom_range(0, 9) == 0);
            end
            tick = ($urandom_range(0, 2) == 0);
            auto_note = 4'($urandom_range(0, 15));
            auto_octave = 4'($urandom_range(0, 15));
            cycle();
        end

        src_press = '0; tick = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
